// File: rtl/clk_gate_idle_ctrl_pkg.sv
// Shared types for the idle-based clock gate controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_gate_idle_ctrl_if.sv
// Requester handshake and downstream busy flag for the clock gate controller.
interface clk_gate_idle_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic               busy;

    modport master (output req, output busy, input ack);
    modport slave  (input req, input busy, output ack);
endinterface

// File: rtl/clk_gate_idle_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module cg_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/clk_gate_idle_ctrl.sv
// Idle-window clock gate controller driving the en pin of an OR-type gate cell.
//   state | meaning
//   RUN   | clock running, requests acknowledged
//   IDLE  | counting down the idle window
//   GATED | gate_off high, clock held
//   WAKE  | clock restarted, waiting WAKE_CYC before acknowledging
module clk_gate_idle_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    clk_gate_idle_ctrl_if.slave bus,
    input  logic                force_on,
    input  logic [IDLE_W-1:0]   idle_thresh,
    input  logic                cnt_clr,
    output logic                gate_off,
    output logic [CNT_W-1:0]    gate_cnt,
    output logic [1:0]          state_o
);
    localparam int CW = max_int(IDLE_W, 4);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYC - 1);

    cg_state_e          state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NUM_REQ-1:0] ack_q;
    logic               wake_ev;
    logic               idle_ev;
    logic               gate_inc;

    assign wake_ev = (|bus.req) | force_on;
    assign idle_ev = !wake_ev && !bus.busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (idle_ev) begin
                    state_nxt = IDLE;
                    cnt_nxt   = CW'(idle_thresh);
                end
            end
            IDLE: begin
                // a wake on the terminal-count cycle must win, so test it first
                if (wake_ev || bus.busy) begin
                    state_nxt = RUN;
                end else if (cnt == '0) begin
                    state_nxt = GATED;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GATED: begin
                if (wake_ev || bus.busy) begin
                    state_nxt = WAKE;
                    cnt_nxt   = WAKE_LOAD;
                end
            end
            WAKE: begin
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // gate_off comes from a flop fed by next-state so the gate latch never sees a glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_off <= 1'b0;
        end else begin
            gate_off <= (state_nxt == GATED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= '0;
        end else begin
            ack_q <= (state == RUN) ? bus.req : '0;
        end
    end

    assign bus.ack  = ack_q;
    assign state_o  = state;
    assign gate_inc = (state == IDLE) && (state_nxt == GATED);

    cg_sat_counter #(
        .W(CNT_W)
    ) u_gate_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (gate_inc),
        .cnt (gate_cnt)
    );
endmodule

// File: tb/tb_clk_gate_idle_ctrl.sv
// Directed bench for clk_gate_idle_ctrl; small CNT_W so saturation is reachable quickly.
module tb_clk_gate_idle_ctrl;
    localparam int NUM_REQ  = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;
    localparam int CNT_W    = 3;

    logic              clk;
    logic              rst;
    logic              force_on;
    logic [IDLE_W-1:0] idle_thresh;
    logic              cnt_clr;
    logic              gate_off;
    logic [CNT_W-1:0]  gate_cnt;
    logic [1:0]        state_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    clk_gate_idle_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

    clk_gate_idle_ctrl #(
        .NUM_REQ  (NUM_REQ),
        .IDLE_W   (IDLE_W),
        .WAKE_CYC (WAKE_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .force_on    (force_on),
        .idle_thresh (idle_thresh),
        .cnt_clr     (cnt_clr),
        .gate_off    (gate_off),
        .gate_cnt    (gate_cnt),
        .state_o     (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one busy pulse from GATED, then wait (bounded) for the block to regate
    task automatic gate_cycle();
        int k;
        bus.busy = 1'b1;
        step(1);
        bus.busy = 1'b0;
        k = 0;
        while (gate_off !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        check_val("loop_regate", 32'(gate_off), 32'd1);
        exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
        check_val("loop_gate_cnt", 32'(gate_cnt), 32'(exp_cnt));
    endtask

    initial begin
        bit seen_gate;
        rst         = 1'b1;
        bus.req     = '0;
        bus.busy    = 1'b0;
        force_on    = 1'b0;
        cnt_clr     = 1'b0;
        idle_thresh = 8'd5;
        step(2);
        check_val("rst_gate_off", 32'(gate_off), 32'd0);
        check_val("rst_ack", 32'(bus.ack), 32'd0);
        check_val("rst_gate_cnt", 32'(gate_cnt), 32'd0);
        check_val("rst_state", 32'(state_o), 32'd0);

        // idle gating with idle_thresh=5: gate_off rises 7 cycles after release
        rst = 1'b0;
        step(6);
        check_val("idle5_pre_gate", 32'(gate_off), 32'd0);
        check_val("idle5_pre_state", 32'(state_o), 32'd1);
        step(1);
        exp_cnt = 1;
        check_val("idle5_gate_off", 32'(gate_off), 32'd1);
        check_val("idle5_gate_cnt", 32'(gate_cnt), 32'(exp_cnt));
        check_val("idle5_state", 32'(state_o), 32'd2);

        // wake on req[2]
        bus.req = 4'b0100;
        step(1);
        check_val("wake_gate_off", 32'(gate_off), 32'd0);
        check_val("wake_state", 32'(state_o), 32'd3);
        check_val("wake_ack0", 32'(bus.ack), 32'd0);
        step(2);
        check_val("wake_run_state", 32'(state_o), 32'd0);
        check_val("wake_ack_early", 32'(bus.ack), 32'd0);
        step(1);
        check_val("wake_ack2", 32'(bus.ack), 32'h4);

        // drop req, load idle window 3, wake exactly on terminal count
        bus.req     = '0;
        idle_thresh = 8'd3;
        step(1);
        check_val("ackdrop_ack", 32'(bus.ack), 32'd0);
        check_val("ackdrop_state", 32'(state_o), 32'd1);
        step(3);
        check_val("tc_state", 32'(state_o), 32'd1);
        bus.req = 4'b0001;
        step(1);
        check_val("tc_run_state", 32'(state_o), 32'd0);
        check_val("tc_gate_off", 32'(gate_off), 32'd0);
        check_val("tc_gate_cnt", 32'(gate_cnt), 32'(exp_cnt));
        step(1);
        check_val("tc_ack0", 32'(bus.ack), 32'h1);

        // force_on holds the clock for 100 idle cycles
        bus.req  = '0;
        force_on = 1'b1;
        seen_gate = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (gate_off !== 1'b0 || state_o !== 2'd0) seen_gate = 1'b1;
        end
        check_val("force_no_gate", 32'(seen_gate), 32'd0);
        force_on    = 1'b0;
        idle_thresh = 8'd0;
        step(1);
        check_val("force_drop_idle", 32'(state_o), 32'd1);
        check_val("force_drop_pre", 32'(gate_off), 32'd0);
        step(1);
        exp_cnt = 2;
        check_val("force_drop_gate", 32'(gate_off), 32'd1);
        check_val("force_drop_cnt", 32'(gate_cnt), 32'(exp_cnt));

        // force_on in GATED wakes but grants nothing
        force_on = 1'b1;
        step(1);
        check_val("fgated_wake", 32'(state_o), 32'd3);
        step(3);
        check_val("fgated_run", 32'(state_o), 32'd0);
        check_val("fgated_ack", 32'(bus.ack), 32'd0);
        force_on = 1'b0;
        step(2);
        exp_cnt = 3;
        check_val("fgated_regate", 32'(gate_off), 32'd1);
        check_val("fgated_cnt", 32'(gate_cnt), 32'(exp_cnt));

        // busy in GATED wakes like a request and blocks regating while held
        bus.busy = 1'b1;
        step(1);
        check_val("busy_wake", 32'(state_o), 32'd3);
        check_val("busy_gate_off", 32'(gate_off), 32'd0);
        step(4);
        check_val("busy_hold_run", 32'(state_o), 32'd0);
        bus.busy = 1'b0;
        step(2);
        exp_cnt = 4;
        check_val("busy_regate", 32'(gate_off), 32'd1);
        check_val("busy_cnt", 32'(gate_cnt), 32'(exp_cnt));

        // saturate at all-ones (7) and hold
        for (int i = 0; i < 5; i++) gate_cycle();
        check_val("sat_hold", 32'(gate_cnt), 32'd7);

        // cnt_clr on the same cycle as a gating event
        bus.busy = 1'b1;
        step(1);
        bus.busy = 1'b0;
        step(3);
        check_val("clr_pre_state", 32'(state_o), 32'd1);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        exp_cnt = 0;
        check_val("clr_state", 32'(state_o), 32'd2);
        check_val("clr_gate_cnt", 32'(gate_cnt), 32'(exp_cnt));

        // async reset mid-GATED
        #3 rst = 1'b1;
        #1;
        check_val("arst_gated_gate_off", 32'(gate_off), 32'd0);
        check_val("arst_gated_state", 32'(state_o), 32'd0);
        step(1);
        rst = 1'b0;
        check_val("arst_gated_rel_state", 32'(state_o), 32'd0);
        step(2);
        check_val("arst_regate", 32'(gate_off), 32'd1);

        // async reset mid-WAKE, req held through it
        bus.req = 4'b0010;
        step(1);
        check_val("arst_wake_pre", 32'(state_o), 32'd3);
        #3 rst = 1'b1;
        #1;
        check_val("arst_wake_gate_off", 32'(gate_off), 32'd0);
        check_val("arst_wake_ack", 32'(bus.ack), 32'd0);
        check_val("arst_wake_state", 32'(state_o), 32'd0);
        step(1);
        rst = 1'b0;
        check_val("arst_wake_rel_state", 32'(state_o), 32'd0);
        step(1);
        check_val("arst_wake_ack1", 32'(bus.ack), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/clk_gate_idle_ctrl.md
# clk_gate_idle_ctrl

Idle-based controller for an OR-type clock gate (enable latch plus OR cell; gate enable high holds the gated clock high). It watches requester activity and a downstream busy flag. After a programmable idle window it gates the clock off, and on any new request it ungates the clock and acknowledges once a fixed wake window has elapsed. It runs on the free-running clock and sits beside the gate cell whose `en` pin it drives.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 1..16.
- `IDLE_W`, 8: width of the idle threshold.
- `WAKE_CYC`, 2: cycles spent in WAKE before acknowledging, 1..15.
- `CNT_W`, 16: width of the gate-event counter.

Ports:
- `clk`, in, 1: ungated source clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req`, in, NUM_REQ: level requests, held until acked.
- `ack`, out, NUM_REQ: per-requester grant; high means the clock is running.
- `busy`, in, 1: downstream logic still active; blocks gating.
- `force_on`, in, 1: config override that keeps the clock ungated.
- `idle_thresh`, in, IDLE_W: idle cycles tolerated before gating; must be quasi-static.
- `cnt_clr`, in, 1: synchronous clear of `gate_cnt`.
- `gate_off`, out, 1: drives the gate cell `en`; 1 means the clock is held high.
- `gate_cnt`, out, CNT_W: saturating count of gating events.
- `state_o`, out, 2: current FSM state, for debug.

## Operation
- FSM states: RUN=0, IDLE=1, GATED=2, WAKE=3.
- `wake_ev` is `|req | force_on`. `idle_ev` is `!wake_ev & !busy`.
- **RUN**: `gate_off`=0.
  - If `idle_ev`: go to IDLE and load `cnt` with `idle_thresh`.
- **IDLE**: `gate_off`=0.
  - If `wake_ev` or `busy`: go to RUN.
  - Otherwise, if `cnt`==0: go to GATED.
  - Otherwise decrement `cnt`.
- **GATED**: `gate_off`=1.
  - If `wake_ev` or `busy`: go to WAKE and load `cnt` with WAKE_CYC-1.
- **WAKE**: `gate_off`=0.
  - If `cnt`==0: go to RUN.
  - Otherwise decrement `cnt`.
  - `req` dropping during WAKE does not abort the sequence.
- **Ack rule**: registered `ack[i] <= (state==RUN) & req[i]`.
  - `ack` falls one cycle after `req` falls, and is forced to 0 in every non-RUN state.
- **gate_off**: registered, and decoded from next-state only, so it is glitch-free into the latch.
- **gate_cnt**:
  - Increments on each IDLE->GATED transition and saturates at all-ones.
  - `cnt_clr` wins over a same-cycle increment; the result is 0.
- **Reset values**: state RUN, `gate_off`=0, `ack`=0, `gate_cnt`=0, `cnt`=0.
- **Async reset mid-operation**: `gate_off` drops immediately, so the clock runs during and after reset.

## Timing
- **Gating latency**: first `idle_ev` cycle at t puts the state in IDLE at t+1.
  - `gate_off` rises at t+2+`idle_thresh`.
  - With `idle_thresh`=0, `gate_off` rises at t+2.
- **Wake latency**: `wake_ev` sampled in GATED at t gives `gate_off`=0 at t+1.
  - The state reaches RUN at t+1+WAKE_CYC.
  - `ack` rises at t+2+WAKE_CYC.
- **Request in RUN**: `ack` one cycle after `req`.
- **Simultaneous `wake_ev` and `cnt`==0 in IDLE**: wake wins and the state returns to RUN; no gating and no count.
- `busy` rising in GATED (not expected, tolerated) wakes the same way as a request.
- `force_on` high: the clock never gates. If `force_on` asserts in GATED, the block wakes, but `ack` stays 0 unless `req` is high.

## Structure
- `clk_gate_ctrl_pkg` holds the state enum `cg_state_e` (2-bit) and the encodings RUN/IDLE/GATED/WAKE.
- One sub-module: `cg_sat_counter` (parameterised width, increment, clear, saturate), used for `gate_cnt`.
- The FSM, the shared `cnt` (width max(IDLE_W, 4)) and the ack registers live in the top level.
- The block does not instantiate the gate cell; the integrator connects `gate_off` to the cell's `en`.

## Test plan
- Reset then idle, `idle_thresh`=5, no `req`/`busy` -> `gate_off` rises 7 cycles after reset release, `gate_cnt`=1, `state_o`=2.
- GATED, pulse `req[2]` high and hold -> `gate_off`=0 next cycle, `ack[2]`=1 exactly 4 cycles after `req` was sampled (WAKE_CYC=2), other `ack` bits 0.
- `idle_thresh`=3, `req[0]` asserted on the cycle `cnt` reaches 0 -> no gating, `gate_cnt` unchanged, `ack[0]` one cycle after RUN.
- `force_on`=1 for 100 idle cycles -> `gate_off` never 1. Drop `force_on` with `idle_thresh`=0 -> `gate_off`=1 two cycles later.
- Preload `gate_cnt` to all-ones by 65535 gate/wake loops (or with a small-CNT_W config) -> further gating holds all-ones. Then `cnt_clr` together with a gating event -> `gate_cnt`=0.
- Assert `rst` asynchronously mid-GATED and mid-WAKE -> `gate_off`=0 and `ack`=0 within the same cycle, `state_o`=0 after release.
